// File: rtl/hazard_tracker_pkg.sv
// Shared types for the register-write tracker: register index width, the
// per-stage in-flight write record and the bubble that fills an empty stage.
package hazard_tracker_pkg;

  localparam int REG_W = 4;

  typedef struct packed {
    logic             valid;
    logic             wb_en;
    logic [REG_W-1:0] dest;
    logic             mem_r;
    logic             mem_w;
  } stage_rec_t;

  localparam stage_rec_t BUBBLE = '0;

  // A stage produces src when it holds a real instruction that writes that register.
  function automatic logic writes_reg(stage_rec_t rec, logic [REG_W-1:0] src);
    return rec.valid & rec.wb_en & (rec.dest == src);
  endfunction

endpackage

// File: rtl/hazard_tracker_stage_rec_reg.sv
// One pipeline-stage record register: loads d (or a bubble) when enabled,
// otherwise holds its contents.
module stage_rec_reg
  import hazard_tracker_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       bubble,
  input  stage_rec_t d,
  output stage_rec_t q
);

  // NOTE: reset is sampled on the clock edge, and state only ever updates
  // with non-blocking assignments so all three stages shift in lockstep.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= BUBBLE;
    end else if (en) begin
      q <= bubble ? BUBBLE : d;
    end
  end

endmodule

// File: rtl/hazard_tracker.sv
// Tracks in-flight register writes through EXE/MEM/WB, raises the ID stall for
// RAW hazards, and freezes the pipeline while the data memory is busy.
module hazard_tracker
  import hazard_tracker_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             forward_en_in,
  input  logic             id_valid_in,
  input  logic [REG_W-1:0] id_src1_in,
  input  logic [REG_W-1:0] id_src2_in,
  input  logic             id_two_src_in,
  input  logic             id_wb_en_in,
  input  logic [REG_W-1:0] id_dest_in,
  input  logic             id_mem_r_en_in,
  input  logic             id_mem_w_en_in,
  input  logic             flush_in,
  input  logic             mem_ready_in,
  output logic             hazard_out,
  output logic             freeze_out,
  output logic             mem_memr_wb_en_out,
  output logic [REG_W-1:0] mem_memr_dest_out,
  output logic             wb_id_wb_en_out,
  output logic [REG_W-1:0] wb_id_wb_dest_out,
  output logic             exe_wb_en_out,
  output logic [REG_W-1:0] exe_dest_out,
  output logic             mem_timeout_out
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);

  stage_rec_t       id_rec, exe_rec, mem_rec, wb_rec;
  logic             advance;
  logic             hit_exe, hit_mem;
  logic [CNT_W-1:0] wait_cnt;

  assign id_rec = '{valid: id_valid_in, wb_en: id_wb_en_in, dest: id_dest_in,
                    mem_r: id_mem_r_en_in, mem_w: id_mem_w_en_in};

  assign hit_exe = writes_reg(exe_rec, id_src1_in) |
                   (id_two_src_in & writes_reg(exe_rec, id_src2_in));
  assign hit_mem = writes_reg(mem_rec, id_src1_in) |
                   (id_two_src_in & writes_reg(mem_rec, id_src2_in));

  // With forwarding only a load in EXE is too late; without it EXE and MEM
  // both block, while WB is covered by the first-half-cycle register write.
  assign hazard_out = id_valid_in &
                      (forward_en_in ? (exe_rec.mem_r & hit_exe) : (hit_exe | hit_mem));

  assign freeze_out = mem_rec.valid & (mem_rec.mem_r | mem_rec.mem_w) & ~mem_ready_in;
  assign advance    = ~freeze_out;

  stage_rec_reg u_exe (
    .clk    (clk),
    .rst    (rst),
    .en     (advance),
    .bubble (hazard_out | flush_in),
    .d      (id_rec),
    .q      (exe_rec)
  );

  stage_rec_reg u_mem (
    .clk    (clk),
    .rst    (rst),
    .en     (advance),
    .bubble (1'b0),
    .d      (exe_rec),
    .q      (mem_rec)
  );

  stage_rec_reg u_wb (
    .clk    (clk),
    .rst    (rst),
    .en     (advance),
    .bubble (1'b0),
    .d      (mem_rec),
    .q      (wb_rec)
  );

  // The timeout flag sets on the same edge the counter reaches MEM_TIMEOUT.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt        <= '0;
      mem_timeout_out <= 1'b0;
    end else if (freeze_out) begin
      if (wait_cnt != CNT_MAX) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (wait_cnt >= CNT_MAX - 1'b1) begin
        mem_timeout_out <= 1'b1;
      end
    end else begin
      wait_cnt <= '0;
    end
  end

  assign exe_wb_en_out      = exe_rec.valid & exe_rec.wb_en;
  assign exe_dest_out       = exe_rec.valid ? exe_rec.dest : '0;
  assign mem_memr_wb_en_out = mem_rec.valid & mem_rec.wb_en;
  assign mem_memr_dest_out  = mem_rec.valid ? mem_rec.dest : '0;
  assign wb_id_wb_en_out    = wb_rec.valid & wb_rec.wb_en;
  assign wb_id_wb_dest_out  = wb_rec.valid ? wb_rec.dest : '0;

  // WB no longer cares whether the instruction touched memory.
  logic unused_wb_mem;
  assign unused_wb_mem = wb_rec.mem_r | wb_rec.mem_w;

endmodule

// File: tb/tb_hazard_tracker.sv
// Directed and randomized bench for hazard_tracker against a pipeline-array
// reference model built from the hazard, freeze and timeout rules.
module tb_hazard_tracker;
  import hazard_tracker_pkg::*;

  localparam int TMO = 4;

  logic             clk;
  logic             rst;
  logic             forward_en_in;
  logic             id_valid_in;
  logic [REG_W-1:0] id_src1_in;
  logic [REG_W-1:0] id_src2_in;
  logic             id_two_src_in;
  logic             id_wb_en_in;
  logic [REG_W-1:0] id_dest_in;
  logic             id_mem_r_en_in;
  logic             id_mem_w_en_in;
  logic             flush_in;
  logic             mem_ready_in;
  logic             hazard_out;
  logic             freeze_out;
  logic             mem_memr_wb_en_out;
  logic [REG_W-1:0] mem_memr_dest_out;
  logic             wb_id_wb_en_out;
  logic [REG_W-1:0] wb_id_wb_dest_out;
  logic             exe_wb_en_out;
  logic [REG_W-1:0] exe_dest_out;
  logic             mem_timeout_out;

  int errors = 0;
  int checks = 0;

  hazard_tracker #(.MEM_TIMEOUT(TMO), .CNT_W(3)) dut (
    .clk                (clk),
    .rst                (rst),
    .forward_en_in      (forward_en_in),
    .id_valid_in        (id_valid_in),
    .id_src1_in         (id_src1_in),
    .id_src2_in         (id_src2_in),
    .id_two_src_in      (id_two_src_in),
    .id_wb_en_in        (id_wb_en_in),
    .id_dest_in         (id_dest_in),
    .id_mem_r_en_in     (id_mem_r_en_in),
    .id_mem_w_en_in     (id_mem_w_en_in),
    .flush_in           (flush_in),
    .mem_ready_in       (mem_ready_in),
    .hazard_out         (hazard_out),
    .freeze_out         (freeze_out),
    .mem_memr_wb_en_out (mem_memr_wb_en_out),
    .mem_memr_dest_out  (mem_memr_dest_out),
    .wb_id_wb_en_out    (wb_id_wb_en_out),
    .wb_id_wb_dest_out  (wb_id_wb_dest_out),
    .exe_wb_en_out      (exe_wb_en_out),
    .exe_dest_out       (exe_dest_out),
    .mem_timeout_out    (mem_timeout_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: pipe[0]=EXE, pipe[1]=MEM, pipe[2]=WB.
  typedef struct {
    bit v;
    bit we;
    int dest;
    bit mr;
    bit mw;
  } mrec_t;

  mrec_t pipe [3];
  int    frozen_run;
  bit    m_tmo;

  function automatic bit m_reads(mrec_t r);
    return r.v && r.we && (r.dest == int'(id_src1_in) ||
                           (id_two_src_in && r.dest == int'(id_src2_in)));
  endfunction

  function automatic bit m_hazard();
    if (!id_valid_in) return 1'b0;
    if (forward_en_in) return pipe[0].mr && m_reads(pipe[0]);
    return m_reads(pipe[0]) || m_reads(pipe[1]);
  endfunction

  function automatic bit m_freeze();
    return pipe[1].v && (pipe[1].mr || pipe[1].mw) && !mem_ready_in;
  endfunction

  function automatic void m_clear();
    for (int s = 0; s < 3; s++) pipe[s] = '{default: 0};
    frozen_run = 0;
    m_tmo      = 1'b0;
  endfunction

  function automatic void m_step();
    bit h;
    bit f;
    h = m_hazard();
    f = m_freeze();
    if (rst) begin
      m_clear();
    end else if (f) begin
      frozen_run++;
      if (frozen_run >= TMO) m_tmo = 1'b1;
    end else begin
      frozen_run = 0;
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      if (h || flush_in) pipe[0] = '{default: 0};
      else pipe[0] = '{v: id_valid_in, we: id_wb_en_in, dest: int'(id_dest_in),
                       mr: id_mem_r_en_in, mw: id_mem_w_en_in};
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("hazard", 32'(hazard_out), 32'(m_hazard()));
    check("freeze", 32'(freeze_out), 32'(m_freeze()));
    check("exe_wb_en", 32'(exe_wb_en_out), 32'(pipe[0].v && pipe[0].we));
    check("exe_dest", 32'(exe_dest_out), 32'(pipe[0].v ? pipe[0].dest : 0));
    check("mem_wb_en", 32'(mem_memr_wb_en_out), 32'(pipe[1].v && pipe[1].we));
    check("mem_dest", 32'(mem_memr_dest_out), 32'(pipe[1].v ? pipe[1].dest : 0));
    check("wb_wb_en", 32'(wb_id_wb_en_out), 32'(pipe[2].v && pipe[2].we));
    check("wb_dest", 32'(wb_id_wb_dest_out), 32'(pipe[2].v ? pipe[2].dest : 0));
    check("timeout", 32'(mem_timeout_out), 32'(m_tmo));
  endtask

  // Entered just after a falling edge with inputs already driven.
  task automatic tick();
    #1;
    check_all();
    @(posedge clk);
    m_step();
    @(negedge clk);
  endtask

  task automatic set_id(input bit v, input int s1, input int s2, input bit two,
                        input bit we, input int d, input bit mr, input bit mw);
    id_valid_in    = v;
    id_src1_in     = REG_W'(s1);
    id_src2_in     = REG_W'(s2);
    id_two_src_in  = two;
    id_wb_en_in    = we;
    id_dest_in     = REG_W'(d);
    id_mem_r_en_in = mr;
    id_mem_w_en_in = mw;
  endtask

  task automatic nop();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst           = 1'b1;
    forward_en_in = 1'b1;
    flush_in      = 1'b0;
    mem_ready_in  = 1'b1;
    nop();
    m_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_hazard", 32'(hazard_out), 32'd0);
    check("rst_freeze", 32'(freeze_out), 32'd0);
    check("rst_exe_wb_en", 32'(exe_wb_en_out), 32'd0);
    check("rst_wb_dest", 32'(wb_id_wb_dest_out), 32'd0);
    check("rst_timeout", 32'(mem_timeout_out), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Load-use with forwarding: one stall cycle, then the load shows in MEM.
    set_id(1, 0, 0, 0, 1, 3, 1, 0); tick();
    set_id(1, 3, 1, 1, 1, 4, 0, 0);
    #1 check("lu_stall", 32'(hazard_out), 32'd1);
    tick();
    #1 check("lu_release", 32'(hazard_out), 32'd0);
    check("lu_exe_bubble", 32'(exe_wb_en_out), 32'd0);
    check("lu_mem_dest", 32'(mem_memr_dest_out), 32'd3);
    check("lu_mem_wb_en", 32'(mem_memr_wb_en_out), 32'd1);
    tick();
    nop(); repeat (3) tick();

    // Forwarding off: dependent instruction stalls two cycles.
    forward_en_in = 1'b0;
    set_id(1, 1, 2, 1, 1, 5, 0, 0); tick();
    set_id(1, 5, 6, 1, 1, 7, 0, 0);
    #1 check("nofwd_stall1", 32'(hazard_out), 32'd1);
    tick();
    #1 check("nofwd_stall2", 32'(hazard_out), 32'd1);
    tick();
    #1 check("nofwd_release", 32'(hazard_out), 32'd0);
    check("nofwd_wb_dest", 32'(wb_id_wb_dest_out), 32'd5);
    tick();
    nop(); repeat (3) tick();

    // Forwarding on, ALU producer: no stall.
    forward_en_in = 1'b1;
    set_id(1, 0, 0, 0, 1, 2, 0, 0); tick();
    set_id(1, 2, 0, 0, 1, 8, 0, 0);
    #1 check("alu_no_stall", 32'(hazard_out), 32'd0);
    tick();
    #1 check("alu_mem_dest", 32'(mem_memr_dest_out), 32'd2);
    nop(); repeat (3) tick();

    // Load stuck in MEM for three cycles, advancing on the fourth edge.
    set_id(1, 0, 0, 0, 1, 9, 1, 0); tick();
    nop(); tick();
    mem_ready_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 check("frz_active", 32'(freeze_out), 32'd1);
      tick();
    end
    mem_ready_in = 1'b1;
    #1 check("frz_released", 32'(freeze_out), 32'd0);
    tick();
    #1 check("frz_wb_dest", 32'(wb_id_wb_dest_out), 32'd9);
    repeat (2) tick();

    // Memory timeout: sticky until reset.
    set_id(1, 0, 0, 0, 1, 10, 1, 0); tick();
    nop(); tick();
    mem_ready_in = 1'b0;
    repeat (10) tick();
    #1 check("tmo_set", 32'(mem_timeout_out), 32'd1);
    mem_ready_in = 1'b1;
    repeat (3) tick();
    #1 check("tmo_sticky", 32'(mem_timeout_out), 32'd1);
    rst = 1'b1; tick();
    rst = 1'b0;
    #1 check("tmo_cleared", 32'(mem_timeout_out), 32'd0);

    // Reset while frozen drops the freeze.
    set_id(1, 0, 0, 0, 1, 11, 1, 0); tick();
    nop(); tick();
    mem_ready_in = 1'b0;
    repeat (2) tick();
    rst = 1'b1; tick();
    rst = 1'b0;
    #1 check("rst_mid_freeze", 32'(freeze_out), 32'd0);
    mem_ready_in = 1'b1;
    tick();

    // Unused src2 never stalls; flush bubbles EXE.
    set_id(1, 0, 0, 0, 1, 11, 1, 0); tick();
    set_id(1, 1, 11, 0, 1, 12, 0, 0);
    #1 check("src2_ignored", 32'(hazard_out), 32'd0);
    flush_in = 1'b1;
    tick();
    flush_in = 1'b0;
    #1 check("flush_bubble", 32'(exe_wb_en_out), 32'd0);
    nop(); tick();

    // Randomized traffic over a small register window to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      rst           = ($urandom_range(0, 49) == 0);
      forward_en_in = ($urandom_range(0, 3) != 0);
      flush_in      = ($urandom_range(0, 7) == 0);
      mem_ready_in  = ($urandom_range(0, 3) != 0);
      set_id($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3),
             $urandom_range(0, 1), ($urandom_range(0, 5) == 0));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_tracker.md
Name: hazard_tracker

Overview:
- Producer side of the pipeline's register-result bypass path.
- Tracks every in-flight register write from ID through EXE, MEM and WB, and drives the per-stage wb_en/dest pairs that the forwarding logic consumes.
- Decides when ID must stall: load-use with forwarding on, any RAW hazard with forwarding off.
- Freezes the whole pipeline while the data memory is not ready, and inserts bubbles on stall and flush.

Parameters:
- REG_W, 4, register index width (16 architectural registers).
- MEM_TIMEOUT, 255, maximum wait cycles for mem_ready_in before mem_timeout_out is set.
- CNT_W, 8, width of the wait counter; must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  synchronous active-high reset.
- forward_en_in  in  1  forwarding enabled (same signal the forwarding logic uses).
- id_valid_in  in  1  ID holds a real instruction.
- id_src1_in  in  REG_W  first source register.
- id_src2_in  in  REG_W  second source register.
- id_two_src_in  in  1  src2 is actually read.
- id_wb_en_in  in  1  ID instruction writes a register.
- id_dest_in  in  REG_W  ID destination register.
- id_mem_r_en_in  in  1  ID instruction is a load.
- id_mem_w_en_in  in  1  ID instruction is a store.
- flush_in  in  1  branch taken in EXE; squash ID.
- mem_ready_in  in  1  data memory ready in MEM stage.
- hazard_out  out  1  stall IF/ID this cycle.
- freeze_out  out  1  hold all pipeline registers.
- mem_memr_wb_en_out  out  1  MEM-stage write enable toward forwarding.
- mem_memr_dest_out  out  REG_W  MEM-stage destination.
- wb_id_wb_en_out  out  1  WB-stage write enable.
- wb_id_wb_dest_out  out  REG_W  WB-stage destination.
- exe_wb_en_out  out  1  EXE-stage write enable.
- exe_dest_out  out  REG_W  EXE-stage destination.
- mem_timeout_out  out  1  sticky memory-timeout flag.

Behaviour:
- Internal stage records, one each for EXE, MEM and WB: {valid, wb_en, dest, mem_r, mem_w}.
- All per-stage outputs are registered, and each is gated by the stage's valid bit.
- Reset: all records, the wait counter and mem_timeout_out clear to 0. Therefore hazard_out=0, freeze_out=0 and all wb_en/dest outputs are 0 in the cycle after rst is seen high.
- Hazard detection is combinational from the current records and ID inputs. A source matches a stage when stage.valid & stage.wb_en & dest==src; src2 is only considered when id_two_src_in=1.
  - forward_en_in=1: hazard_out = id_valid_in & EXE.mem_r & (src1 or src2 matches EXE).
  - forward_en_in=0: hazard_out = id_valid_in & (src1 or src2 matches EXE or MEM). WB is excluded because the register file writes in the first half-cycle.
- freeze_out = MEM.valid & (MEM.mem_r | MEM.mem_w) & ~mem_ready_in. It is combinational.
- Advance on each clk edge:
  - freeze_out=1: all records hold; hazard_out is still computed but has no effect on the records.
  - Otherwise: WB<=MEM and MEM<=EXE.
  - EXE <= bubble (valid=0) if hazard_out | flush_in, else the ID fields with valid=id_valid_in.
- flush_in and hazard_out together: bubble once. flush_in is not held across freeze; the caller must reassert it.
- Wait counter:
  - Increments on every frozen cycle and saturates at MEM_TIMEOUT.
  - Clears on any non-frozen cycle.
  - When it reaches MEM_TIMEOUT, mem_timeout_out sets and stays set until rst.
- Reset mid-freeze: rst wins, and freeze_out drops the cycle after reset.

Decomposition:
- Shared package: REG_W, a stage-record typedef {valid, wb_en, dest, mem_r, mem_w}, and a bubble constant.
- One sub-module, stage_rec_reg: a record register with enable (hold) and bubble input, instantiated three times.

Test Plan:
- Forwarding on; EXE holds load r3; ID reads r3 as src1 -> hazard_out=1 for exactly 1 cycle. EXE becomes a bubble, then the next cycle mem_memr_dest_out=3 and mem_memr_wb_en_out=1.
- Forwarding off; ADD r5 followed by SUB reading r5 -> hazard_out=1 for 2 cycles. Then hazard_out=0 with wb_id_wb_dest_out=5.
- Forwarding on; non-load writes r2, next instruction reads r2 -> hazard_out=0. The MEM outputs show r2 the following cycle.
- Load in MEM with mem_ready_in=0 for 3 cycles -> freeze_out=1 for 3 cycles with all outputs unchanged. Advance occurs on the 4th edge.
- MEM_TIMEOUT=4; mem_ready_in held low 10 cycles -> mem_timeout_out rises after the 4th frozen cycle and stays 1 after ready returns, until rst.
- id_two_src_in=0 with src2 matching EXE load dest -> no hazard. flush_in=1 -> EXE bubble, so exe_wb_en_out=0 next cycle.
